// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared address window, register offsets and FSM state type for spi_ctrl
package spi_ctrl_pkg;

    // Peripheral window as seen by the top-level decoder; spi_ctrl itself only sees
    // base-stripped offsets, so only the window size matters inside the block.
    localparam logic [31:0] spi_base_addr = 32'h4000_0000;
    localparam logic [31:0] spi_top_addr  = 32'h4000_000F;

    // Register select values for spi_addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_RXDATA = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_shift.sv
// rtl/spi_shift.sv - 8-bit mode-0 SPI shift engine with programmable half-period counter
//
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   start           launch a transfer (only honoured while idle)
//   tx_byte         byte to send, MSB first
//   clk_div         half-period length minus one, sampled at each half-period boundary
//   busy            high in LO, HI and DONE
//   done            one-cycle pulse in DONE; rx_byte is valid in that cycle
//   rx_byte         received byte
//   sclk, mosi      SPI clock (idle low) and serial data out
//   miso            serial data in, sampled on the rising SCLK edge
module spi_shift
    import spi_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rx_byte,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso
);

    spi_state_t           state;
    logic [7:0]           shift_reg;
    logic [2:0]           bit_cnt;
    logic [DIV_WIDTH-1:0] half_cnt;
    logic [DIV_WIDTH-1:0] half_div;
    logic                 half_end;

    // half_div is a snapshot of clk_div taken at every half-period boundary, so a
    // CTRL write mid-period never lets half_cnt run past its terminal value.
    assign half_end = (half_cnt == half_div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            half_cnt  <= '0;
            half_div  <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg <= tx_byte;
                        bit_cnt   <= 3'd0;
                        mosi      <= tx_byte[7];
                        half_cnt  <= '0;
                        half_div  <= clk_div;
                        state     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (half_end) begin
                        // Rising SCLK edge: capture miso into the vacated LSB
                        shift_reg <= {shift_reg[6:0], miso};
                        sclk      <= 1'b1;
                        half_cnt  <= '0;
                        half_div  <= clk_div;
                        state     <= ST_HI;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_HI: begin
                    if (half_end) begin
                        sclk     <= 1'b0;
                        half_cnt <= '0;
                        half_div <= clk_div;
                        if (bit_cnt == 3'd7) begin
                            mosi  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            // The register was shifted on the rising edge, so bit 7
                            // now holds the next bit to send.
                            mosi    <= shift_reg[7];
                            state   <= ST_LO;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign rx_byte = shift_reg;

endmodule

// File: rtl/spi_ctrl.sv
// rtl/spi_ctrl.sv - memory-mapped SPI master: bus responder, registers, TXDATA stall
//
// Optional feature macro: SPI_IRQ_EN (adds spi_irpt and the R/W CTRL.irq_en bit)
//
// Ports:
//   clk, rst               system clock, synchronous active-low reset
//   spi_valid/instr/addr/  request from the core; held until spi_ready
//   spi_wdata/wstrb        (wstrb==0 is a read, instr=1 is a side-effect-free fetch)
//   spi_rdata, spi_ready   read data and one-cycle completion pulse
//   spi_sclk, spi_mosi     SPI clock (idle low) and serial out, MSB first
//   spi_miso               serial in
//   spi_cs_n               chip select, straight from CTRL.cs_n
//   spi_irpt               (SPI_IRQ_EN only) irq_en & rx_valid, registered
module spi_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_valid,
    input  logic        spi_instr,
    input  logic [31:0] spi_addr,
    input  logic [31:0] spi_wdata,
    input  logic [3:0]  spi_wstrb,
    output logic [31:0] spi_rdata,
    output logic        spi_ready,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
`ifdef SPI_IRQ_EN
    ,
    output logic        spi_irpt
`endif
);

    logic [DIV_WIDTH-1:0] clk_div;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_valid_nxt;

    logic                 sh_busy;
    logic                 sh_done;
    logic [7:0]           rx_byte;

    logic [1:0]           reg_sel;
    logic                 in_win;
    logic                 rd_req;
    logic                 wr_req;
    logic                 tx_launch_req;
    logic                 stall;
    logic                 accept;
    logic                 launch;
    logic                 ctrl_wr;
    logic [31:0]          rd_val;
    logic                 unused_bits;

`ifdef SPI_IRQ_EN
    logic                 irq_en;
    logic                 irq_en_nxt;
`endif

    assign reg_sel = spi_addr[3:2];
    assign in_win  = (spi_addr <= (spi_top_addr - spi_base_addr));

    // Fetches never write and never clear rx_valid, so they are neither reads nor writes here
    assign rd_req = in_win && !spi_instr && (spi_wstrb == 4'b0000);
    assign wr_req = in_win && !spi_instr && (spi_wstrb != 4'b0000);

    assign tx_launch_req = wr_req && (reg_sel == REG_TXDATA) && spi_wstrb[0];

    // Only a launching TXDATA write waits for the engine; everything else completes at latency 1
    assign stall   = tx_launch_req && sh_busy;
    assign accept  = spi_valid && !spi_ready && !stall;
    assign launch  = accept && tx_launch_req;
    assign ctrl_wr = accept && wr_req && (reg_sel == REG_CTRL);

    assign unused_bits = ^spi_wdata;

    always_comb begin
        rd_val = 32'h0;
        if (rd_req) begin
            case (reg_sel)
                REG_CTRL: begin
                    rd_val[DIV_WIDTH-1:0] = clk_div;
                    rd_val[8]             = spi_cs_n;
`ifdef SPI_IRQ_EN
                    rd_val[9]             = irq_en;
`endif
                end
                REG_STATUS: rd_val[1:0] = {rx_valid, sh_busy};
                REG_RXDATA: rd_val[7:0] = rx_data;
                default:    rd_val      = 32'h0;
            endcase
        end
    end

    // A completing transfer outranks an RXDATA read in the same cycle
    always_comb begin
        rx_valid_nxt = rx_valid;
        if (accept && rd_req && (reg_sel == REG_RXDATA)) begin
            rx_valid_nxt = 1'b0;
        end
        if (sh_done) begin
            rx_valid_nxt = 1'b1;
        end
    end

`ifdef SPI_IRQ_EN
    always_comb begin
        irq_en_nxt = irq_en;
        if (ctrl_wr && spi_wstrb[1]) begin
            irq_en_nxt = spi_wdata[9];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            spi_ready <= 1'b0;
            spi_rdata <= 32'h0;
            clk_div   <= DIV_RESET;
            spi_cs_n  <= 1'b1;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
`ifdef SPI_IRQ_EN
            irq_en    <= 1'b0;
            spi_irpt  <= 1'b0;
`endif
        end else begin
            spi_ready <= accept;
            spi_rdata <= accept ? rd_val : 32'h0;
            rx_valid  <= rx_valid_nxt;
            if (sh_done) begin
                rx_data <= rx_byte;
            end
            if (ctrl_wr) begin
                if (spi_wstrb[0]) begin
                    clk_div <= spi_wdata[DIV_WIDTH-1:0];
                end
                if (spi_wstrb[1]) begin
                    spi_cs_n <= spi_wdata[8];
                end
            end
`ifdef SPI_IRQ_EN
            irq_en   <= irq_en_nxt;
            // Built from next-state values so the interrupt rises with rx_valid
            spi_irpt <= irq_en_nxt & rx_valid_nxt;
`endif
        end
    end

    spi_shift #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (launch),
        .tx_byte (spi_wdata[7:0]),
        .clk_div (clk_div),
        .busy    (sh_busy),
        .done    (sh_done),
        .rx_byte (rx_byte),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi),
        .miso    (spi_miso)
    );

endmodule
